fire_ctrl: RTL and testbench
============================

# fire_ctrl

Converts the joystick fire button into a clean, single-cycle `Bullet_Fired` request for the bullet stage, and sits directly upstream of the Bullet module on `game_clk`. It synchronises and debounces the raw button, then edge-detects the press. Firing is gated on game state and bullet availability, and a cooldown follows each shot. It also keeps a saturating shot counter for the scoreboard/SSD path.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required to accept a new button level; legal range 1–15.
- `COOLDOWN_CYCLES`, default 8: cycles spent in cooldown after each shot; legal range 1–255.
- `Clk` input, 1 bit: game clock; one clock domain only.
- `Reset` input, 1 bit: asynchronous, active-high.
- `Btn_Raw` input, 1 bit: raw joystick fire button (jstkData[1]); asynchronous to `Clk`.
- `Game_Active` input, 1 bit: high while the game is in play.
- `Bullet_Onscreen` input, 1 bit: from Bullet; high while a bullet is in flight.
- `Bullet_Fired` output, 1 bit: registered, one-cycle fire request to Bullet.
- `Fire_Ready` output, 1 bit: registered; high when a press would fire now.
- `Shots_Fired` output, 8 bits: registered count of issued shots; saturates.

## Operation
- **Reset values:** `Bullet_Fired`=0, `Fire_Ready`=0, `Shots_Fired`=0. Synchroniser flops, debounced level and debounce counter are all 0. State is S_IDLE.
- **Synchroniser:** two flops, `Btn_Raw` → sync1 → sync2.
- **Debounce:**
  - Each cycle that sync2 differs from the debounced level, the counter increments.
  - Any cycle where they are equal clears the counter.
  - When the counter reaches `DEBOUNCE_CYCLES`, the debounced level flips and the counter clears.
  - `press` = a 0→1 transition of the debounced level; it lasts one cycle.
- **FSM:**
  - **S_IDLE:** on `press` && `Game_Active` && !`Bullet_Onscreen`, go to S_FIRE. A press arriving under any other condition is discarded; it is not queued.
  - **S_FIRE:** lasts one cycle. `Bullet_Fired` is high throughout. `Shots_Fired` increments, holding at 255. Then go to S_COOLDOWN and load the cooldown counter with `COOLDOWN_CYCLES`.
  - **S_COOLDOWN:** the counter decrements each cycle. When it reaches 0, go to S_WAIT_RELEASE.
  - **S_WAIT_RELEASE:** when the debounced level is 0, go to S_IDLE.
- **Game_Active low:**
  - In any state other than S_FIRE, the next state is S_IDLE and the cooldown counter clears.
  - An S_FIRE already entered still completes its pulse.
  - `Shots_Fired` is preserved.
- **`Fire_Ready`:** registered value of (next state == S_IDLE) && `Game_Active` && !`Bullet_Onscreen`.
- **Simultaneous events:** if `press` and a `Bullet_Onscreen` rise occur in the same cycle, the press is lost. The player must release and re-press.
- **Reset mid-operation:** all state returns to reset values immediately. A pulse in progress is truncated.

## Timing
- Take edge 1 as the first rising edge at which `Btn_Raw`=1, with the button held steady.
  - sync2 goes high after edge 2.
  - The debounced level goes high after edge 2+`DEBOUNCE_CYCLES`.
  - `Bullet_Fired` is high for exactly the cycle following edge 3+`DEBOUNCE_CYCLES` (edge 7 at default).
- `Shots_Fired` updates on the same edge that asserts `Bullet_Fired`.
- Minimum spacing between two pulses is 1+`COOLDOWN_CYCLES`+release debounce+re-press debounce cycles.
- `Bullet_Fired` never stays high for two consecutive cycles.

## Configuration
- **`FIRE_AUTOFIRE_EN` defined:** when S_COOLDOWN expires, the FSM checks the debounced level.
  - If it is still 1 and `Game_Active` && !`Bullet_Onscreen`, go directly to S_FIRE.
  - If it is 1 but those conditions fail, go to S_WAIT_RELEASE.
  - If it is 0, go to S_IDLE.
  - Holding the button therefore fires repeatedly.
- **Undefined (default):** the FSM always passes through S_WAIT_RELEASE, giving one shot per press.

## Structure
- Shared package `invaders_pkg` holds:
  - the state enum (S_IDLE, S_FIRE, S_COOLDOWN, S_WAIT_RELEASE, 2-bit encoding);
  - the default constants for `DEBOUNCE_CYCLES` and `COOLDOWN_CYCLES`;
  - the `SHOT_CNT_W`=8 constant.
- Sub-module `btn_debounce` holds the synchroniser, debounce counter and rise-edge output. It is reusable for the other buttons. The FSM and counters stay in `fire_ctrl`.

## Test plan
- **Basic fire:** reset, then `Game_Active`=1, `Bullet_Onscreen`=0; raise `Btn_Raw` at edge 1 and hold 100 cycles → a single `Bullet_Fired` pulse, in the cycle after edge 7; `Shots_Fired`=1 (autofire off).
- **Bounce rejection:** `Btn_Raw` toggles high 3 cycles / low 1 cycle repeatedly for 40 cycles → no pulse and no count change.
- **Gating:** `Bullet_Onscreen`=1 during the press → no pulse and `Fire_Ready`=0. Releasing, clearing `Bullet_Onscreen`, then re-pressing → a pulse 7 cycles after the re-press.
- **Saturation:** 260 clean press/release cycles → `Shots_Fired` stops at 255 while `Bullet_Fired` pulses continue.
- **Autofire:** with `FIRE_AUTOFIRE_EN` defined, hold the button 60 cycles → pulses at cycle 7, then every 9 cycles (7, 16, 25, 34, 43, 52).
- **Reset mid-cooldown:** assert `Reset` 3 cycles after a pulse → all outputs 0 at once; after release, a new press fires with the normal 7-cycle latency.

Source files
------------

// File: rtl/invaders_pkg.sv
// Shared types and constants for the invaders game-control blocks.
// Holds the fire-control state encoding, default timing constants and the
// shot-counter width, plus a saturating increment used by the counters.
package invaders_pkg;

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_FIRE         = 2'd1,
    S_COOLDOWN     = 2'd2,
    S_WAIT_RELEASE = 2'd3
  } fire_state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int COOLDOWN_CYCLES_DEF = 8;
  localparam int SHOT_CNT_W          = 8;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [SHOT_CNT_W-1:0] sat_inc(input logic [SHOT_CNT_W-1:0] v);
    logic [SHOT_CNT_W-1:0] r;
    r = v;
    if (v != {SHOT_CNT_W{1'b1}}) r = v + 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stable-level debounce, rise pulse.
// Latency: level follows a steady input 2+DEBOUNCE_CYCLES edges later; o_rise
// is a registered one-cycle pulse aligned with the level's 0->1 flip.
import invaders_pkg::*;

module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_raw,
  output logic o_level,
  output logic o_rise
);

  // Counter holds at most DEBOUNCE_CYCLES-1 (<= 14), so 4 bits suffice.
  localparam logic [3:0] LP_LAST = 4'(DEBOUNCE_CYCLES - 1);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_level;
  logic       r_rise;
  logic [3:0] r_cnt;

  // Synchronise the raw button, then accept a new level only after it has
  // differed from the current level for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= 4'd0;
    end else begin
      r_sync1 <= i_btn_raw;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      if (r_sync2 != r_level) begin
        if (r_cnt == LP_LAST) begin
          r_level <= r_sync2;
          r_rise  <= r_sync2;
          r_cnt   <= 4'd0;
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
      end else begin
        r_cnt <= 4'd0;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;

endmodule

// File: rtl/fire_ctrl.sv
// Fire control: debounced press -> single-cycle Bullet_Fired, gated, with cooldown
// and a saturating shot counter. Press-to-pulse: pulse in the cycle after edge
// 3+DEBOUNCE_CYCLES. Optional FIRE_AUTOFIRE_EN: holding the button refires.
import invaders_pkg::*;

module fire_ctrl #(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int COOLDOWN_CYCLES = COOLDOWN_CYCLES_DEF
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Btn_Raw,
  input  logic                  Game_Active,
  input  logic                  Bullet_Onscreen,
  output logic                  Bullet_Fired,
  output logic                  Fire_Ready,
  output logic [SHOT_CNT_W-1:0] Shots_Fired
);

  localparam logic [7:0] LP_COOL = 8'(COOLDOWN_CYCLES);

  fire_state_t           r_state;
  fire_state_t           w_next_state;
  logic [7:0]            r_cool_cnt;
  logic [7:0]            w_cool_nxt;
  logic                  r_bullet_fired;
  logic                  r_fire_ready;
  logic [SHOT_CNT_W-1:0] r_shots;
  logic                  w_level;
  logic                  w_press;
  logic                  w_fire_ok;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .i_clk     (Clk),
    .i_rst     (Reset),
    .i_btn_raw (Btn_Raw),
    .o_level   (w_level),
    .o_rise    (w_press)
  );

  assign w_fire_ok = Game_Active && !Bullet_Onscreen;

  // Next-state and cooldown-counter logic; a press not accepted in S_IDLE is dropped.
  always_comb begin
    w_next_state = r_state;
    w_cool_nxt   = r_cool_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_press && w_fire_ok) w_next_state = S_FIRE;
      end
      S_FIRE: begin
        w_next_state = S_COOLDOWN;
        w_cool_nxt   = LP_COOL;
      end
      S_COOLDOWN: begin
        // Leaving on the edge where the counter hits zero gives 1+COOLDOWN spacing.
        if (r_cool_cnt <= 8'd1) begin
          w_cool_nxt = 8'd0;
`ifdef FIRE_AUTOFIRE_EN
          if (w_level && w_fire_ok) w_next_state = S_FIRE;
          else if (w_level)         w_next_state = S_WAIT_RELEASE;
          else                      w_next_state = S_IDLE;
`else
          w_next_state = S_WAIT_RELEASE;
`endif
        end else begin
          w_cool_nxt = r_cool_cnt - 8'd1;
        end
      end
      S_WAIT_RELEASE: begin
        if (!w_level) w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
        w_cool_nxt   = 8'd0;
      end
    endcase
    // Leaving play aborts everything except a shot already being issued.
    if (!Game_Active && (r_state != S_FIRE)) begin
      w_next_state = S_IDLE;
      w_cool_nxt   = 8'd0;
    end
  end

  // State, cooldown counter and registered outputs; shot count bumps on the firing edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state        <= S_IDLE;
      r_cool_cnt     <= 8'd0;
      r_bullet_fired <= 1'b0;
      r_fire_ready   <= 1'b0;
      r_shots        <= '0;
    end else begin
      r_state        <= w_next_state;
      r_cool_cnt     <= w_cool_nxt;
      r_bullet_fired <= (w_next_state == S_FIRE);
      r_fire_ready   <= (w_next_state == S_IDLE) && w_fire_ok;
      if (w_next_state == S_FIRE) r_shots <= sat_inc(r_shots);
    end
  end

  assign Bullet_Fired = r_bullet_fired;
  assign Fire_Ready   = r_fire_ready;
  assign Shots_Fired  = r_shots;

endmodule

// File: tb/tb_fire_ctrl.sv
// Directed bench for fire_ctrl: basic fire, bounce rejection, gating,
// counter saturation, and reset during cooldown.
// Pulse times are recorded relative to edge 1 of each press.
module tb_fire_ctrl;

`ifdef FIRE_AUTOFIRE_EN
  localparam int EXP_N = 6;
`else
  localparam int EXP_N = 1;
`endif

  logic       Clk;
  logic       Reset;
  logic       Btn_Raw;
  logic       Game_Active;
  logic       Bullet_Onscreen;
  logic       Bullet_Fired;
  logic       Fire_Ready;
  logic [7:0] Shots_Fired;

  int n_vec;
  int n_err;
  int edge_cnt;
  int base;
  int pulses[$];

  fire_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .COOLDOWN_CYCLES (8)
  ) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .Btn_Raw         (Btn_Raw),
    .Game_Active     (Game_Active),
    .Bullet_Onscreen (Bullet_Onscreen),
    .Bullet_Fired    (Bullet_Fired),
    .Fire_Ready      (Fire_Ready),
    .Shots_Fired     (Shots_Fired)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial edge_cnt = 0;
  always @(posedge Clk) edge_cnt <= edge_cnt + 1;

  // Log the press-relative edge number after which each pulse is seen.
  always @(negedge Clk) begin
    if (Bullet_Fired) pulses.push_back(edge_cnt - base + 1);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge: the next posedge is edge 1 of the press.
  task automatic press(input int hold, input int rel);
    Btn_Raw = 1'b1;
    base    = edge_cnt + 1;
    repeat (hold) @(negedge Clk);
    Btn_Raw = 1'b0;
    repeat (rel) @(negedge Clk);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    base  = 0;
    Reset = 1'b1;
    Btn_Raw = 1'b0;
    Game_Active = 1'b0;
    Bullet_Onscreen = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst_fired", int'(Bullet_Fired), 0);
    chk("rst_ready", int'(Fire_Ready), 0);
    chk("rst_shots", int'(Shots_Fired), 0);

    Reset = 1'b0;
    Game_Active = 1'b1;
    repeat (2) @(negedge Clk);
    chk("idle_ready", int'(Fire_Ready), 1);

    // Basic fire (held long enough to exercise autofire when enabled)
    pulses.delete();
    press(54, 20);
    chk("basic_npulse", pulses.size(), EXP_N);
    for (int i = 0; i < pulses.size() && i < EXP_N; i++)
      chk("basic_time", pulses[i], 7 + 9 * i);
    chk("basic_shots", int'(Shots_Fired), EXP_N);
    chk("basic_ready", int'(Fire_Ready), 1);

    // Bounce: high 3 / low 1 never stays stable for 4 cycles
    pulses.delete();
    for (int i = 0; i < 40; i++) begin
      Btn_Raw = ((i % 4) != 3);
      @(negedge Clk);
    end
    Btn_Raw = 1'b0;
    repeat (10) @(negedge Clk);
    chk("bounce_npulse", pulses.size(), 0);
    chk("bounce_shots", int'(Shots_Fired), EXP_N);

    // Gating by bullet in flight
    Bullet_Onscreen = 1'b1;
    repeat (2) @(negedge Clk);
    chk("gate_ready_busy", int'(Fire_Ready), 0);
    pulses.delete();
    press(8, 12);
    chk("gate_npulse_busy", pulses.size(), 0);
    chk("gate_ready_busy2", int'(Fire_Ready), 0);
    Bullet_Onscreen = 1'b0;
    repeat (2) @(negedge Clk);
    chk("gate_ready_free", int'(Fire_Ready), 1);
    pulses.delete();
    press(8, 12);
    chk("gate_npulse", pulses.size(), 1);
    if (pulses.size() > 0) chk("gate_time", pulses[0], 7);
    chk("gate_shots", int'(Shots_Fired), EXP_N + 1);

    // Saturation: 260 clean presses
    pulses.delete();
    repeat (260) press(8, 12);
    chk("sat_npulse", pulses.size(), 260);
    chk("sat_shots", int'(Shots_Fired), 255);

    // Reset three cycles after a pulse, during cooldown
    pulses.delete();
    Btn_Raw = 1'b1;
    base = edge_cnt + 1;
    repeat (8) @(negedge Clk);
    Btn_Raw = 1'b0;
    repeat (2) @(negedge Clk);
    chk("rstmid_npulse", pulses.size(), 1);
    chk("rstmid_pre_shots", int'(Shots_Fired), 255);
    #2 Reset = 1'b1;
    #1;
    chk("rstmid_fired", int'(Bullet_Fired), 0);
    chk("rstmid_ready", int'(Fire_Ready), 0);
    chk("rstmid_shots", int'(Shots_Fired), 0);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    chk("post_rst_ready", int'(Fire_Ready), 1);
    pulses.delete();
    press(8, 12);
    chk("post_rst_npulse", pulses.size(), 1);
    if (pulses.size() > 0) chk("post_rst_time", pulses[0], 7);
    chk("post_rst_shots", int'(Shots_Fired), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
